// File: rtl/life_cell_seq.sv
`default_nettype none
// ============================================================================
// Module   : life_cell_seq
// Brief    : Game-of-Life cell that sums one neighbour per tick over an
//            8-tick window and applies the birth/survive rule at tick 7.
// Revision : 1.0  initial release
// ============================================================================
module life_cell_seq #(
  parameter logic [8:0] BIRTH_MASK   = 9'b000001000,
  parameter logic [8:0] SURVIVE_MASK = 9'b000001100,
  parameter logic       INIT_STATE   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] tick,
  input  logic [7:0] neighbors,
  input  logic       load,
  input  logic       load_value,
  output logic       state,
  output logic [3:0] live_count,
  output logic       gen_pulse,
  output logic       seq_err
);

  // Masks padded to 16 entries so any 4-bit total is a legal index.
  localparam logic [15:0] C_BIRTH   = {7'b0, BIRTH_MASK};
  localparam logic [15:0] C_SURVIVE = {7'b0, SURVIVE_MASK};

  logic       state_q, state_d;
  logic [3:0] live_count_q, live_count_d;
  logic       gen_pulse_q, gen_pulse_d;
  logic       seq_err_q, seq_err_d;
  logic [3:0] acc_q, acc_d;
  logic       window_valid_q, window_valid_d;
  logic [2:0] prev_tick_q, prev_tick_d;

  logic [2:0] w_exp_tick;
  logic       w_err;
  logic [3:0] w_bit;
  logic [3:0] w_total;

  always_comb begin
    w_exp_tick = prev_tick_q + 3'd1;
    // A tick 0 is always checked so that a window ending early is caught.
    w_err      = (window_valid_q || (tick == 3'd0)) && (tick != w_exp_tick);
    w_bit      = {3'b000, neighbors[tick]};
    w_total    = acc_q + w_bit;

    state_d        = state_q;
    live_count_d   = live_count_q;
    gen_pulse_d    = 1'b0;
    seq_err_d      = seq_err_q;
    acc_d          = acc_q;
    window_valid_d = window_valid_q;
    prev_tick_d    = tick;

    if (w_err) begin
      seq_err_d      = 1'b1;
      window_valid_d = 1'b0;
    end

    if (tick == 3'd0) begin
      acc_d          = w_bit;
      window_valid_d = 1'b1;
    end else if (window_valid_q && !w_err) begin
      if (tick == 3'd7) begin
        live_count_d   = w_total;
        state_d        = state_q ? C_SURVIVE[w_total] : C_BIRTH[w_total];
        gen_pulse_d    = 1'b1;
        window_valid_d = 1'b0;
      end else begin
        acc_d = w_total;
      end
    end

    if (load) begin
      state_d = load_value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= INIT_STATE;
      live_count_q   <= 4'd0;
      gen_pulse_q    <= 1'b0;
      seq_err_q      <= 1'b0;
      acc_q          <= 4'd0;
      window_valid_q <= 1'b0;
      prev_tick_q    <= 3'd0;
    end else begin
      state_q        <= state_d;
      live_count_q   <= live_count_d;
      gen_pulse_q    <= gen_pulse_d;
      seq_err_q      <= seq_err_d;
      acc_q          <= acc_d;
      window_valid_q <= window_valid_d;
      prev_tick_q    <= prev_tick_d;
    end
  end

  assign state      = state_q;
  assign live_count = live_count_q;
  assign gen_pulse  = gen_pulse_q;
  assign seq_err    = seq_err_q;

endmodule
`default_nettype wire

// File: doc/life_cell_seq.md
Name: life_cell_seq

Overview:
- Game-of-Life cell engine driven by the 3-bit tick counter of the 8-tick timer.
- Samples one neighbour per tick, accumulates a live-neighbour count over an 8-tick window, and applies the birth/survive rule once per window at tick 7.
- Sits between the 8-tick timer and the cell grid; its `state` output feeds the neighbour inputs of the adjacent cells.

Parameters:
- BIRTH_MASK, 9'b000001000, bit n set -> dead cell with n live neighbours becomes alive (B3).
- SURVIVE_MASK, 9'b000001100, bit n set -> live cell with n live neighbours stays alive (S23).
- INIT_STATE, 1'b0, value loaded into `state` on reset.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- tick  input  3  current tick 0-7 from the 8-tick timer.
- neighbors  input  8  neighbour live bits; neighbors[i] is sampled on the edge where tick==i.
- load  input  1  force `state` to load_value on this edge.
- load_value  input  1  value written when load is high.
- state  output  1  registered cell state (1 = alive).
- live_count  output  4  total neighbour count of the last completed window (0-8).
- gen_pulse  output  1  high for exactly one cycle after each rule update.
- seq_err  output  1  sticky flag: tick sequence violation detected.

Behaviour:
- Clock and reset: single clock domain; rst is synchronous and active-high; all outputs are registered.
- Reset values: state=INIT_STATE, live_count=0, gen_pulse=0, seq_err=0. Internal accumulator acc=0, window_valid=0, prev_tick=0.
- Reset mid-window: everything above clears, and the partial window is discarded. The timer also sits at tick 0 while rst is high. After rst falls, the next sampled tick is 1, so the first window only becomes valid at the next tick==0 seen with rst low.
- Window start: on an edge with rst=0 and tick==0:
  - acc <= neighbors[0];
  - window_valid <= 1.
- Accumulate: on an edge with tick in 1..6 and window_valid=1:
  - acc <= acc + neighbors[tick];
  - acc is 4 bits and never exceeds 8, so it never wraps.
- Rule update: on an edge with tick==7 and window_valid=1:
  - total = acc + neighbors[7];
  - live_count <= total;
  - state <= state ? SURVIVE_MASK[total] : BIRTH_MASK[total];
  - gen_pulse <= 1 on the next cycle only;
  - window_valid <= 0.
- Latency: the new state is visible on the cycle after the tick-7 edge, the same cycle gen_pulse is high.
- Sequence check:
  - prev_tick records tick every non-reset edge.
  - While window_valid=1 (or on the tick==0 that ends a window), a tick != prev_tick+1 mod 8 sets seq_err <= 1 and window_valid <= 0. No rule update happens for that window.
  - An unexpected tick==0 still starts a new window (window_valid <= 1) in addition to setting seq_err.
  - seq_err clears only on rst.
- Windows outside a valid window: ticks arriving while window_valid=0 (other than 0) are ignored. No accumulation and no error.
- Load:
  - load=1 sets state <= load_value on that edge, regardless of tick.
  - Load during tick 7 of a valid window: load wins for state. live_count and gen_pulse still update as normal, and window_valid still clears.
  - load does not affect acc or the sequence check.
- Mask boundaries: total=0 and total=8 index mask bits 0 and 8. Both must be honoured, e.g. BIRTH_MASK bit 0 set gives birth with zero neighbours.
- Steady state: with a continuous 0..7 tick stream, one update occurs every 8 cycles with no gaps.

Test Plan:
- Reset then run: rst high 3 cycles, release, feed the timer sequence 1..7,0..7; neighbors=8'b00000111, INIT_STATE=0 -> no gen_pulse in the partial window; after the first full window gen_pulse=1 once, live_count=3, state=1 (birth).
- Survival and death:
  - state=1 (via load), neighbors=8'b00000011 -> live_count=2, state stays 1.
  - next window neighbors=8'b11110000 -> live_count=4, state=0.
  - all-ones window -> live_count=8, state=0, no overflow.
- Per-tick sampling: neighbors changes every cycle so that only the bit indexed by the current tick is 1 -> live_count=8, proving the index-per-tick sampling.
- Sequence error: ticks 0,1,2,5,6,7 -> seq_err=1, no gen_pulse, state unchanged. Next clean 0..7 window updates normally, and seq_err stays 1 until rst.
- Load collision: load=1, load_value=0 on the tick-7 edge of a window with count 3 and state 0 -> state=0, live_count=3, gen_pulse=1. Following window behaves normally.
- Reset mid-window: assert rst at tick 4 -> all outputs return to reset values next cycle, no gen_pulse for the interrupted window, and seq_err is not set after release.
